// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - execute/memory/decode side bundle of the regfile writeback controller
//
// Purpose: groups every non-clock signal of regfile_wb_ctrl.
//   master: pipeline side; drives requests and decode operands, receives enables and PC control.
//   slave : controller side.
// Signals:
//   alu_valid/alu_addr            ALU result write request and destination
//   wb_valid/wb_addr              base-writeback request and destination
//   ldr_issue/ldr_issue_addr      load issued this cycle and its destination
//   ldr_done/ldr_done_addr        load data returning this cycle and its destination
//   rd_addr_a/b/shift/str         source registers of the decode instruction
//   dst_addr/dst_valid            destination of the decode instruction
//   w_en1/w_en2/w_en_ldr          regfile write enables
//   sel_pc/load_pc                PC mux select and load strobe
//   stall/flush                   decode hold and younger-instruction kill
//   pending                       load scoreboard, bit n = load to Rn in flight
interface regfile_wb_ctrl_if;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        ldr_issue;
  logic [3:0]  ldr_issue_addr;
  logic        ldr_done;
  logic [3:0]  ldr_done_addr;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [3:0]  rd_addr_shift;
  logic [3:0]  rd_addr_str;
  logic [3:0]  dst_addr;
  logic        dst_valid;
  logic        w_en1;
  logic        w_en2;
  logic        w_en_ldr;
  logic [1:0]  sel_pc;
  logic        load_pc;
  logic        stall;
  logic        flush;
  logic [15:0] pending;

  modport master (
    output alu_valid, alu_addr, wb_valid, wb_addr,
    output ldr_issue, ldr_issue_addr, ldr_done, ldr_done_addr,
    output rd_addr_a, rd_addr_b, rd_addr_shift, rd_addr_str, dst_addr, dst_valid,
    input  w_en1, w_en2, w_en_ldr, sel_pc, load_pc, stall, flush, pending
  );

  modport slave (
    input  alu_valid, alu_addr, wb_valid, wb_addr,
    input  ldr_issue, ldr_issue_addr, ldr_done, ldr_done_addr,
    input  rd_addr_a, rd_addr_b, rd_addr_shift, rd_addr_str, dst_addr, dst_valid,
    output w_en1, w_en2, w_en_ldr, sel_pc, load_pc, stall, flush, pending
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - regfile write-port gating, load scoreboard and PC sequencing
//
// Purpose: gates the three regfile write ports (w1 = ALU, w2 = base writeback,
//   ldr = load return), tracks loads in flight and stalls decode on RAW/WAW
//   hazards, and sequences the PC through start-up, redirect and flush.
// Ports:
//   clk   in  clock, all state on the rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of regfile_wb_ctrl_if (requests in; enables, PC control,
//         stall, flush and pending scoreboard out)
// Parameters:
//   MAX_LDR       loads allowed in flight, 1..4
//   FLUSH_CYCLES  bubble cycles after a PC redirect, 1..7
module regfile_wb_ctrl #(
  parameter int MAX_LDR      = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_LDR + 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  fcnt;
  logic [CW-1:0] ldr_cnt;
  logic [15:0] pending;
  logic        hold_valid;
  logic [3:0]  hold_addr;

  logic        w_en1;
  logic        w_en_ldr;
  logic        wb_req;
  logic        wb_hit;
  logic        hold_hit;
  logic        hold_drain;
  logic        hold_next;
  logic        redirect;
  logic        hazard;
  logic [15:0] pending_next;

  // Write-port arbitration. Everything is gated by rst so requests in a reset
  // cycle never reach the regfile.
  always_comb begin
    w_en_ldr   = !rst && bus.ldr_done && (bus.ldr_done_addr != 4'd0);
    w_en1      = !rst && bus.alu_valid && (bus.alu_addr != 4'd0) && (state != FLUSH);
    hold_hit   = hold_valid &&
                 ((w_en1 && (bus.alu_addr == hold_addr)) ||
                  (w_en_ldr && (bus.ldr_done_addr == hold_addr)));
    hold_drain = !rst && hold_valid && !hold_hit;
    wb_req     = !rst && bus.wb_valid && (bus.wb_addr != 4'd0);
    // An occupied buffer owns the w2 port this cycle, so a fresh request parks too.
    wb_hit     = wb_req &&
                 (hold_valid ||
                  (w_en1 && (bus.wb_addr == bus.alu_addr)) ||
                  (w_en_ldr && (bus.wb_addr == bus.ldr_done_addr)));
    // Buffer occupancy after this edge; decode stalls while a write is parked.
    hold_next  = (hold_valid && !hold_drain) || wb_hit;
  end

  // Scoreboard update: a set to the same register wins over a clear.
  always_comb begin
    pending_next = pending;
    if (bus.ldr_done) pending_next[bus.ldr_done_addr] = 1'b0;
    if (bus.ldr_issue && (bus.ldr_issue_addr != 4'd0)) pending_next[bus.ldr_issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Hazard check uses the current scoreboard, so a load returning this cycle
  // still stalls its consumer; release follows one cycle later.
  always_comb begin
    hazard = pending[bus.rd_addr_a] || pending[bus.rd_addr_b] ||
             pending[bus.rd_addr_shift] || pending[bus.rd_addr_str] ||
             (bus.dst_valid && pending[bus.dst_addr]) ||
             (ldr_cnt == CW'(MAX_LDR)) || hold_next;
    redirect = !rst && (state == RUN) && bus.alu_valid && (bus.alu_addr == 4'd15);
  end

  // PC control depends on same-cycle requests, so it is decoded from state
  // rather than registered.
  always_comb begin
    bus.sel_pc  = 2'b01;
    bus.load_pc = 1'b1;
    bus.stall   = 1'b1;
    bus.flush   = 1'b1;
    if (!rst) begin
      case (state)
        RUN: begin
          bus.stall   = hazard;
          bus.sel_pc  = redirect ? 2'b10 : 2'b00;
          bus.load_pc = redirect | ~hazard;
          bus.flush   = redirect;
        end
        FLUSH: begin
          bus.sel_pc  = 2'b00;
          bus.load_pc = 1'b1;
          bus.stall   = 1'b0;
          bus.flush   = 1'b1;
        end
        default: begin
          bus.sel_pc  = 2'b01;
          bus.load_pc = 1'b1;
          bus.stall   = 1'b1;
          bus.flush   = 1'b1;
        end
      endcase
    end
  end

  assign bus.w_en1    = w_en1;
  assign bus.w_en_ldr = w_en_ldr;
  assign bus.w_en2    = hold_drain || (wb_req && !wb_hit);
  assign bus.pending  = pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      fcnt       <= 3'd0;
      ldr_cnt    <= '0;
      pending    <= 16'h0000;
      hold_valid <= 1'b0;
      hold_addr  <= 4'd0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (redirect) begin
            state <= FLUSH;
            fcnt  <= 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (fcnt == 3'd0) state <= RUN;
          else              fcnt  <= fcnt - 3'd1;
        end
        default: state <= INIT;
      endcase

      pending <= pending_next;

      // Loads to R0 are still counted so that their return balances the count.
      if (bus.ldr_issue && !bus.ldr_done) begin
        ldr_cnt <= ldr_cnt + CW'(1);
      end else if (!bus.ldr_issue && bus.ldr_done && (ldr_cnt != '0)) begin
        ldr_cnt <= ldr_cnt - CW'(1);
      end

      // A parked write that cannot drain keeps the buffer; otherwise it is
      // refilled by this cycle's conflicting request, if any.
      if (!hold_valid || hold_drain) begin
        hold_valid <= wb_hit;
        hold_addr  <= bus.wb_addr;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.MAX_LDR(2), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_addr = 0; bus.wb_valid = 0; bus.wb_addr = 0;
    bus.ldr_issue = 0; bus.ldr_issue_addr = 0; bus.ldr_done = 0; bus.ldr_done_addr = 0;
    bus.rd_addr_a = 0; bus.rd_addr_b = 0; bus.rd_addr_shift = 0; bus.rd_addr_str = 0;
    bus.dst_addr = 0; bus.dst_valid = 0;
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it and
  // outputs checked #1 later, well clear of both clock edges.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    cyc();
    // requests during reset are dropped
    bus.alu_valid = 1; bus.alu_addr = 3;
    #1;
    chk("rst_stall", bus.stall, 1);
    chk("rst_sel_pc", bus.sel_pc, 2'b01);
    chk("rst_load_pc", bus.load_pc, 1);
    chk("rst_flush", bus.flush, 1);
    chk("rst_w_en1", bus.w_en1, 0);
    cyc();
    chk("rst_pending", bus.pending, 16'h0000);

    // start-up: INIT then RUN
    idle(); rst = 1'b0;
    #1;
    chk("init_sel_pc", bus.sel_pc, 2'b01);
    chk("init_load_pc", bus.load_pc, 1);
    chk("init_stall", bus.stall, 1);
    cyc();
    chk("run_sel_pc", bus.sel_pc, 2'b00);
    chk("run_stall", bus.stall, 0);
    chk("run_load_pc", bus.load_pc, 1);

    // load to R5 and its consumer
    bus.ldr_issue = 1; bus.ldr_issue_addr = 5;
    #1; chk("issue_r5_stall", bus.stall, 0);
    cyc();
    bus.ldr_issue = 0; bus.rd_addr_a = 5;
    #1;
    chk("raw_r5_stall", bus.stall, 1);
    chk("raw_r5_pending", bus.pending, 16'h0020);
    chk("raw_r5_load_pc", bus.load_pc, 0);
    bus.ldr_done = 1; bus.ldr_done_addr = 5;
    #1;
    chk("done_r5_stall", bus.stall, 1);
    chk("done_r5_w_en_ldr", bus.w_en_ldr, 1);
    cyc();
    bus.ldr_done = 0;
    #1;
    chk("rel_r5_stall", bus.stall, 0);
    chk("rel_r5_pending", bus.pending, 16'h0000);

    // two loads in flight hit the MAX_LDR limit
    idle(); bus.ldr_issue = 1; bus.ldr_issue_addr = 3;
    cyc();
    bus.ldr_issue_addr = 4;
    cyc();
    bus.ldr_issue = 0;
    #1;
    chk("max_ldr_stall", bus.stall, 1);
    chk("max_ldr_pending", bus.pending, 16'h0018);
    bus.ldr_done = 1; bus.ldr_done_addr = 3;
    #1; chk("max_ldr_done_stall", bus.stall, 1);
    cyc();
    bus.ldr_done = 0;
    #1; chk("one_ldr_stall", bus.stall, 0);
    bus.dst_valid = 1; bus.dst_addr = 4;
    #1; chk("waw_r4_stall", bus.stall, 1);
    bus.dst_valid = 0; bus.ldr_done = 1; bus.ldr_done_addr = 4;
    cyc();
    bus.ldr_done = 0;
    #1; chk("drain_pending", bus.pending, 16'h0000);

    // ALU vs base writeback on R7
    bus.alu_valid = 1; bus.alu_addr = 7; bus.wb_valid = 1; bus.wb_addr = 7;
    #1;
    chk("conf_w_en1", bus.w_en1, 1);
    chk("conf_w_en2", bus.w_en2, 0);
    chk("conf_stall", bus.stall, 1);
    cyc();
    idle();
    #1;
    chk("held_w_en2", bus.w_en2, 1);
    chk("held_stall", bus.stall, 0);
    chk("held_w_en1", bus.w_en1, 0);
    cyc();
    chk("after_held_w_en2", bus.w_en2, 0);

    // load return vs base writeback on R9
    bus.ldr_done = 1; bus.ldr_done_addr = 9; bus.wb_valid = 1; bus.wb_addr = 9;
    #1;
    chk("ldr_conf_w_en_ldr", bus.w_en_ldr, 1);
    chk("ldr_conf_w_en2", bus.w_en2, 0);
    cyc();
    idle();
    #1; chk("ldr_held_w_en2", bus.w_en2, 1);
    bus.wb_valid = 1; bus.wb_addr = 2;
    cyc();
    bus.wb_valid = 0;
    #1; chk("queued_wb_w_en2", bus.w_en2, 1);
    cyc();

    // branch redirect through R15
    bus.alu_valid = 1; bus.alu_addr = 15;
    #1;
    chk("br_sel_pc", bus.sel_pc, 2'b10);
    chk("br_load_pc", bus.load_pc, 1);
    chk("br_flush", bus.flush, 1);
    cyc();
    bus.alu_addr = 6;
    #1;
    chk("fl1_flush", bus.flush, 1);
    chk("fl1_w_en1", bus.w_en1, 0);
    chk("fl1_sel_pc", bus.sel_pc, 2'b00);
    chk("fl1_stall", bus.stall, 0);
    cyc();
    chk("fl2_flush", bus.flush, 1);
    chk("fl2_w_en1", bus.w_en1, 0);
    cyc();
    chk("post_fl_flush", bus.flush, 0);
    chk("post_fl_w_en1", bus.w_en1, 1);

    // R0 on every port
    idle();
    bus.alu_valid = 1; bus.wb_valid = 1; bus.ldr_done = 1; bus.ldr_issue = 1;
    #1;
    chk("r0_w_en1", bus.w_en1, 0);
    chk("r0_w_en2", bus.w_en2, 0);
    chk("r0_w_en_ldr", bus.w_en_ldr, 0);
    cyc();
    idle();
    #1;
    chk("r0_pending", bus.pending, 16'h0000);
    chk("r0_stall", bus.stall, 0);

    // reset mid-run drops requests and restarts at INIT
    rst = 1; bus.alu_valid = 1; bus.alu_addr = 3;
    #1;
    chk("mid_rst_w_en1", bus.w_en1, 0);
    chk("mid_rst_stall", bus.stall, 1);
    cyc();
    idle(); rst = 0;
    #1; chk("mid_rst_init_sel", bus.sel_pc, 2'b01);
    cyc();
    chk("mid_rst_run_sel", bus.sel_pc, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
